// File: rtl/hazard_pkg.sv
// Shared opcode constants and FSM state type for the hazard controller.
package hazard_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] WB_SEL_MEM = 2'b01;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } haz_state_t;

endpackage

// File: rtl/fwd_prio_match.sv
// Priority match of one decode source register against the older writers;
// the youngest matching stage wins, select is stage index plus one.
module fwd_prio_match #(
  parameter int FWD_DEPTH = 2,
  localparam int SEL_W = $clog2(FWD_DEPTH + 1)
) (
  input  logic [4:0]             rs,
  input  logic                   used,
  input  logic [5*FWD_DEPTH-1:0] wrRd,
  input  logic [FWD_DEPTH-1:0]   wrEn,
  input  logic                   youngIsLoad,
  output logic [SEL_W-1:0]       sel,
  output logic                   loadHit
);

  // Walk oldest to youngest so the last assignment is the youngest match.
  always_comb begin
    sel = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (used && (rs != 5'd0) && wrEn[k] && (wrRd[5*k +: 5] == rs)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

  assign loadHit = youngIsLoad && (sel == SEL_W'(1));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Forwarding / load-use stall / branch flush controller with registered outputs.
// Optional saturating performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int FWD_DEPTH    = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  localparam int SEL_W       = $clog2(FWD_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [31:0]            id_instr,
  input  logic [5*FWD_DEPTH-1:0] wr_rd,
  input  logic [FWD_DEPTH-1:0]   wr_en,
  input  logic [FWD_DEPTH-1:0]   wr_is_load,
  input  logic                   br_taken,
  output logic [SEL_W-1:0]       fwd_sel_a,
  output logic [SEL_W-1:0]       fwd_sel_b,
  output logic                   stall,
  output logic                   stall_mw,
  output logic                   flush,
  output haz_state_t             dbgState
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_flush_cnt,
  output logic [31:0]            perf_fwd_cnt
`endif
);

  localparam int CNT_MAX = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       useA;
  logic       useB;
  logic       unusedInstr;

  assign opcode      = id_instr[6:0];
  assign rs1         = id_instr[19:15];
  assign rs2         = id_instr[24:20];
  assign unusedInstr = ^{id_instr[31:25], id_instr[14:7], wr_is_load};

  assign useA = id_valid && !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) ||
                              (opcode == OPC_JAL));
  assign useB = id_valid && ((opcode == OPC_OP) || (opcode == OPC_STORE) ||
                             (opcode == OPC_BRANCH));

  logic [SEL_W-1:0] selA;
  logic [SEL_W-1:0] selB;
  logic             loadHitA;
  logic             loadHitB;
  logic             loadUse;

  fwd_prio_match #(.FWD_DEPTH(FWD_DEPTH)) u_match_a (
    .rs          (rs1),
    .used        (useA),
    .wrRd        (wr_rd),
    .wrEn        (wr_en),
    .youngIsLoad (wr_is_load[0]),
    .sel         (selA),
    .loadHit     (loadHitA)
  );

  fwd_prio_match #(.FWD_DEPTH(FWD_DEPTH)) u_match_b (
    .rs          (rs2),
    .used        (useB),
    .wrRd        (wr_rd),
    .wrEn        (wr_en),
    .youngIsLoad (wr_is_load[0]),
    .sel         (selB),
    .loadHit     (loadHitB)
  );

  assign loadUse = loadHitA || loadHitB;

  haz_state_t       state, stateNext;
  logic [CNT_W-1:0] stallCnt, stallCntNext;
  logic [CNT_W-1:0] flushCnt, flushCntNext;
  logic [SEL_W-1:0] selAQ, selANext;
  logic [SEL_W-1:0] selBQ, selBNext;
  logic             stallQ, stallNext;
  logic             flushQ, flushNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      stallCnt <= '0;
      flushCnt <= '0;
      selAQ    <= '0;
      selBQ    <= '0;
      stallQ   <= 1'b0;
      flushQ   <= 1'b0;
    end else begin
      state    <= stateNext;
      stallCnt <= stallCntNext;
      flushCnt <= flushCntNext;
      selAQ    <= selANext;
      selBQ    <= selBNext;
      stallQ   <= stallNext;
      flushQ   <= flushNext;
    end
  end

  // Each branch computes the output values that become visible after this edge.
  // A branch always wins; counters leave their state once they would hit zero.
  always_comb begin
    stateNext    = state;
    stallCntNext = stallCnt;
    flushCntNext = flushCnt;
    selANext     = '0;
    selBNext     = '0;
    stallNext    = 1'b0;
    flushNext    = 1'b0;
    if (br_taken) begin
      stateNext    = FLUSH;
      flushCntNext = CNT_W'(FLUSH_CYCLES);
      stallCntNext = '0;
      flushNext    = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (loadUse) begin
            stateNext    = LOAD_STALL;
            stallCntNext = CNT_W'(LOAD_LAT);
            stallNext    = 1'b1;
          end else begin
            selANext = selA;
            selBNext = selB;
          end
        end
        LOAD_STALL: begin
          if (stallCnt <= CNT_W'(1)) begin
            stateNext    = RUN;
            stallCntNext = '0;
            selANext     = selA;
            selBNext     = selB;
          end else begin
            stallCntNext = stallCnt - CNT_W'(1);
            stallNext    = 1'b1;
          end
        end
        FLUSH: begin
          if (flushCnt <= CNT_W'(1)) begin
            stateNext    = RUN;
            flushCntNext = '0;
            selANext     = selA;
            selBNext     = selB;
          end else begin
            flushCntNext = flushCnt - CNT_W'(1);
            flushNext    = 1'b1;
          end
        end
        default: begin
          stateNext    = RUN;
          stallCntNext = '0;
          flushCntNext = '0;
        end
      endcase
    end
  end

  assign fwd_sel_a = selAQ;
  assign fwd_sel_b = selBQ;
  assign stall     = stallQ;
  assign stall_mw  = stallQ;
  assign flush     = flushQ;
  assign dbgState  = state;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stallQ && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flushQ && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
      if (((selAQ != '0) || (selBQ != '0)) && (perf_fwd_cnt != 32'hFFFF_FFFF)) begin
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with FWD_DEPTH=2, LOAD_LAT=2, FLUSH_CYCLES=2.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [9:0]  wr_rd;
  logic [1:0]  wr_en;
  logic [1:0]  wr_is_load;
  logic        br_taken;
  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic        stall;
  logic        stall_mw;
  logic        flush;
  haz_state_t  dbgState;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl_unit #(.FWD_DEPTH(2), .LOAD_LAT(2), .FLUSH_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .wr_rd      (wr_rd),
    .wr_en      (wr_en),
    .wr_is_load (wr_is_load),
    .br_taken   (br_taken),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b),
    .stall      (stall),
    .stall_mw   (stall_mw),
    .flush      (flush),
    .dbgState   (dbgState)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_valid   = 1'b0;
    id_instr   = 32'h0000_0013;
    wr_rd      = 10'd0;
    wr_en      = 2'b00;
    wr_is_load = 2'b00;
    br_taken   = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL reset_sel_a act=%0d exp=0", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 2'd0) begin errors++; $display("FAIL reset_sel_b act=%0d exp=0", fwd_sel_b); end
    checks++; if ({stall, stall_mw, flush} !== 3'b000) begin errors++; $display("FAIL reset_ctl act=%b exp=000", {stall, stall_mw, flush}); end
    checks++; if (dbgState !== RUN) begin errors++; $display("FAIL reset_state act=%0d exp=%0d", dbgState, RUN); end
`ifdef HAZ_PERF_CNT_EN
    checks++; if ({perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt} !== 96'd0) begin errors++; $display("FAIL reset_perf act=%0d/%0d/%0d exp=0", perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt); end
`endif
  endtask

  task automatic test_forwarding();
    // Both stages write x5: youngest (stage 0) wins on both operands.
    drive_idle();
    id_valid = 1'b1;
    id_instr = mk_r(5'd6, 5'd5, 5'd5);
    wr_rd    = {5'd5, 5'd5};
    wr_en    = 2'b11;
    tick();
    checks++; if (fwd_sel_a !== 2'd1) begin errors++; $display("FAIL fwd_both_a act=%0d exp=1", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 2'd1) begin errors++; $display("FAIL fwd_both_b act=%0d exp=1", fwd_sel_b); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_both_stall act=%b exp=0", stall); end
    // sub x1,x2,x5 with stage0=x2, stage1=x5.
    id_instr = mk_r(5'd1, 5'd2, 5'd5);
    wr_rd    = {5'd5, 5'd2};
    tick();
    checks++; if (fwd_sel_a !== 2'd1) begin errors++; $display("FAIL fwd_split_a act=%0d exp=1", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 2'd2) begin errors++; $display("FAIL fwd_split_b act=%0d exp=2", fwd_sel_b); end
    // Stage 0 not writing: falls back to stage 1 for rs1.
    wr_rd = {5'd2, 5'd2};
    wr_en = 2'b10;
    tick();
    checks++; if (fwd_sel_a !== 2'd2) begin errors++; $display("FAIL fwd_en_a act=%0d exp=2", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 2'd0) begin errors++; $display("FAIL fwd_en_b act=%0d exp=0", fwd_sel_b); end
    // addi: rs2 field matches a writer but rs2 is unused.
    id_instr = mk_i(5'd3, 5'd4, 12'd7);
    wr_rd    = {5'd4, 5'd7};
    wr_en    = 2'b11;
    tick();
    checks++; if (fwd_sel_a !== 2'd2) begin errors++; $display("FAIL addi_a act=%0d exp=2", fwd_sel_a); end
    checks++; if (fwd_sel_b !== 2'd0) begin errors++; $display("FAIL addi_b act=%0d exp=0", fwd_sel_b); end
    // Invalid decode slot: no forwarding.
    id_valid = 1'b0;
    tick();
    checks++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL invalid_a act=%0d exp=0", fwd_sel_a); end
  endtask

  task automatic test_x0_and_unused();
    drive_idle();
    id_valid = 1'b1;
    id_instr = mk_i(5'd0, 5'd0, 12'd1);
    wr_rd    = {5'd0, 5'd0};
    wr_en    = 2'b11;
    tick();
    checks++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL x0_a act=%0d exp=0", fwd_sel_a); end
    // LUI x7 whose immediate places 7 in the rs1 field.
    id_instr = {12'h000, 5'd7, 3'b000, 5'd7, OPC_LUI};
    wr_rd    = {5'd0, 5'd7};
    wr_en    = 2'b01;
    wr_is_load = 2'b01;
    tick();
    checks++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL lui_a act=%0d exp=0", fwd_sel_a); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lui_stall act=%b exp=0", stall); end
  endtask

  task automatic test_load_use();
    drive_idle();
    id_valid   = 1'b1;
    id_instr   = mk_r(5'd1, 5'd9, 5'd2);
    wr_rd      = {5'd0, 5'd9};
    wr_en      = 2'b01;
    wr_is_load = 2'b01;
    tick();
    checks++; if ({stall, stall_mw} !== 2'b11) begin errors++; $display("FAIL lu_c1 act=%b exp=11", {stall, stall_mw}); end
    checks++; if ({fwd_sel_a, fwd_sel_b} !== 4'd0) begin errors++; $display("FAIL lu_c1_sel act=%h exp=0", {fwd_sel_a, fwd_sel_b}); end
    checks++; if (dbgState !== LOAD_STALL) begin errors++; $display("FAIL lu_state act=%0d exp=%0d", dbgState, LOAD_STALL); end
    tick();
    checks++; if ({stall, stall_mw} !== 2'b11) begin errors++; $display("FAIL lu_c2 act=%b exp=11", {stall, stall_mw}); end
    checks++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL lu_c2_sel act=%0d exp=0", fwd_sel_a); end
    // Load has moved on to stage 1.
    wr_rd      = {5'd9, 5'd0};
    wr_en      = 2'b10;
    wr_is_load = 2'b00;
    tick();
    checks++; if ({stall, stall_mw} !== 2'b00) begin errors++; $display("FAIL lu_exit act=%b exp=00", {stall, stall_mw}); end
    checks++; if (fwd_sel_a !== 2'd2) begin errors++; $display("FAIL lu_exit_a act=%0d exp=2", fwd_sel_a); end
    checks++; if (dbgState !== RUN) begin errors++; $display("FAIL lu_exit_state act=%0d exp=%0d", dbgState, RUN); end
`ifdef HAZ_PERF_CNT_EN
    checks++; if (perf_stall_cnt !== 32'd2) begin errors++; $display("FAIL perf_stall act=%0d exp=2", perf_stall_cnt); end
`endif
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_after act=%b exp=0", stall); end
  endtask

  task automatic test_flush();
    drive_idle();
    br_taken = 1'b1;
    tick();
    br_taken = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fl1_c1 act=%b exp=1", flush); end
    checks++; if (dbgState !== FLUSH) begin errors++; $display("FAIL fl1_state act=%0d exp=%0d", dbgState, FLUSH); end
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fl1_c2 act=%b exp=1", flush); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL fl1_c3 act=%b exp=0", flush); end
    // Restart during the flush: three flush cycles in total.
    br_taken = 1'b1;
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fl2_c1 act=%b exp=1", flush); end
    tick();
    br_taken = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fl2_c2 act=%b exp=1", flush); end
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fl2_c3 act=%b exp=1", flush); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL fl2_c4 act=%b exp=0", flush); end
  endtask

  task automatic test_branch_vs_load();
    drive_idle();
    id_valid   = 1'b1;
    id_instr   = mk_r(5'd1, 5'd9, 5'd2);
    wr_rd      = {5'd0, 5'd9};
    wr_en      = 2'b01;
    wr_is_load = 2'b01;
    br_taken   = 1'b1;
    tick();
    br_taken = 1'b0;
    checks++; if ({flush, stall} !== 2'b10) begin errors++; $display("FAIL bl_c1 act=%b exp=10", {flush, stall}); end
    tick();
    checks++; if ({flush, stall, stall_mw} !== 3'b100) begin errors++; $display("FAIL bl_c2 act=%b exp=100", {flush, stall, stall_mw}); end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({flush, stall} !== 2'b00) begin errors++; $display("FAIL bl_tail%0d act=%b exp=00", i, {flush, stall}); end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_idle();
    id_valid   = 1'b1;
    id_instr   = mk_r(5'd1, 5'd9, 5'd9);
    wr_rd      = {5'd0, 5'd9};
    wr_en      = 2'b01;
    wr_is_load = 2'b01;
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rs_pre act=%b exp=1", stall); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({stall, stall_mw, flush, fwd_sel_a, fwd_sel_b} !== 7'd0) begin errors++; $display("FAIL rs_async act=%b exp=0", {stall, stall_mw, flush, fwd_sel_a, fwd_sel_b}); end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if ({stall, stall_mw, flush, fwd_sel_a, fwd_sel_b} !== 7'd0) begin errors++; $display("FAIL rs_idle act=%b exp=0", {stall, stall_mw, flush, fwd_sel_a, fwd_sel_b}); end
    checks++; if (dbgState !== RUN) begin errors++; $display("FAIL rs_state act=%0d exp=%0d", dbgState, RUN); end
`ifdef HAZ_PERF_CNT_EN
    checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL rs_perf act=%0d exp=0", perf_stall_cnt); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_forwarding();
    test_x0_and_unused();
    test_load_use();
    test_flush();
    test_branch_vs_load();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
